i2c_slave: RTL

Synthesizable I2C target (responder) that pairs with `i2c_master` on the shared `scl`/`sda` bus. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a fixed 7-bit address, ACKs accepted bytes and delivers written bytes to local logic. It serves read bytes supplied by local logic. No clock stretching. It drives SDA open-drain only: it pulls SDA low or releases it.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_slave_if.sv | 17 +
 rtl/i2c_pin_sync.sv | 57 +++++
 rtl/i2c_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target.
//   - i2c_state_e : protocol FSM states
//   - I2C_ADDR_W  : width of the device address
//   - I2C_WR/I2C_RD : encodings of the R/W bit that follows the address
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam logic I2C_WR     = 1'b0;
  localparam logic I2C_RD     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: the I2C pin bundle as seen by a target.
//   scl_in  : SCL pin value
//   sda_in  : SDA pin value (wired-AND of every driver on the bus)
//   sda_out : SDA drive value, always 0 (open drain)
//   sda_oen : 1 pulls SDA low, 0 releases it
// Modport slave is used by the target; modport master is the bus side.
interface i2c_slave_if;

  logic scl_in;
  logic sda_in;
  logic sda_out;
  logic sda_oen;

  modport slave  (input scl_in, input sda_in, output sda_out, output sda_oen);
  modport master (output scl_in, output sda_in, input sda_out, input sda_oen);

endinterface

// File: rtl/i2c_pin_sync.sv
// i2c_pin_sync: pin conditioning for the I2C target.
// Two-flop synchronizer on SCL and SDA plus one history flop; all bus
// events are decoded from the synchronized pair and registered, so every
// output is a one-cycle pulse appearing 3 clk after the pin change.
//   clk, rst_n          : system clock, async active-low reset
//   scl_in, sda_in      : raw pin values
//   scl_rise, scl_fall  : SCL edge pulses
//   start_det, stop_det : SDA falling / rising while SCL is high
//   sda_s               : synchronized SDA aligned with the event pulses
module i2c_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // Idle bus reads high, so the chain resets to 1 to avoid phantom events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0    <= 1'b1;
      scl_p1    <= 1'b1;
      scl_p2    <= 1'b1;
      sda_p0    <= 1'b1;
      sda_p1    <= 1'b1;
      sda_p2    <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      // p0/p1: metastability filter
      scl_p0    <= scl_in;
      sda_p0    <= sda_in;
      scl_p1    <= scl_p0;
      sda_p1    <= sda_p0;
      // p2: previous synchronized value for edge detection
      scl_p2    <= scl_p1;
      sda_p2    <= sda_p1;
      // event stage
      scl_rise  <= scl_p1 & ~scl_p2;
      scl_fall  <= ~scl_p1 & scl_p2;
      start_det <= scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
      stop_det  <= scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
      sda_s     <= sda_p1;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with a fixed 7-bit address, no clock stretching.
//   clk, rst_n : system clock, async active-low reset
//   bus        : I2C pins (scl_in, sda_in, sda_out, sda_oen), open drain
//   rx_data    : last byte written by the master, valid with rx_en
//   rx_en      : one-cycle pulse per received data byte
//   tx_req     : one-cycle pulse asking for the next read byte
//   tx_data    : read byte, captured 2 clk after tx_req
//   flag_start : pulse on START / repeated START
//   flag_stop  : pulse on STOP
//   addr_match : high from address ACK until the next START/STOP
//   busy       : high between START and STOP
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_slave_if.slave        bus,
  output logic [7:0]        rx_data,
  output logic              rx_en,
  output logic              tx_req,
  input  logic [7:0]        tx_data,
  output logic              flag_start,
  output logic              flag_stop,
  output logic              addr_match,
  output logic              busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_pin_sync u_pin_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       oen_q, oen_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] tx_buf_q;
  logic [7:0] rx_data_d;
  logic       rx_en_d, tx_req_d, start_d, stop_d, addr_match_d, busy_d;
  logic       tx_req_p1;
  logic [7:0] shifted;

  // Byte as it stands once the bit currently on SDA is shifted in.
  assign shifted = {rx_sh_q, sda_s};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    oen_d        = oen_q;
    rx_sh_d      = rx_sh_q;
    tx_sh_d      = tx_sh_q;
    rx_data_d    = rx_data;
    rx_en_d      = 1'b0;
    tx_req_d     = 1'b0;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    addr_match_d = addr_match;
    busy_d       = busy;

    // Bus conditions take priority over any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d      = ADDR;
      start_d      = 1'b1;
      oen_d        = 1'b0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
    end else if (stop_det) begin
      state_d      = IDLE;
      stop_d       = 1'b1;
      oen_d        = 1'b0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            rx_sh_d = shifted[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shifted[7:1] == SLAVE_ADDR) begin
                state_d      = ADDR_ACK;
                rw_d         = shifted[0];
                addr_match_d = 1'b1;
                // Ask for the first read byte early so it is captured well
                // before the fall that puts its MSB on the bus.
                tx_req_d     = (shifted[0] == I2C_RD);
              end else begin
                state_d = IDLE;
                oen_d   = 1'b0;
              end
            end
          end
        end

        // cnt 0: the fall ending bit 8 starts the ACK drive.
        // cnt 1: the fall ending the ACK slot releases SDA, or for a read
        //        immediately presents the MSB of the buffered byte.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oen_d = 1'b1;
              cnt_d = 3'd1;
            end else if (state_q == WR_ACK || rw_q == I2C_WR) begin
              oen_d   = 1'b0;
              state_d = WR_DATA;
            end else begin
              state_d = RD_DATA;
              oen_d   = ~tx_buf_q[7];
              tx_sh_d = {tx_buf_q[6:0], 1'b0};
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            rx_sh_d = shifted[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d = shifted;
              rx_en_d   = 1'b1;
              state_d   = WR_ACK;
            end
          end
        end

        // Bit 7 is already on the bus at entry; falls 0..6 present bits
        // 6..0 and the eighth fall hands SDA back to the master.
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oen_d   = 1'b0;
              state_d = RD_ACK;
            end else begin
              oen_d   = ~tx_sh_q[7];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end

        // cnt becomes 1 once the master has ACKed; the next fall then
        // starts the following byte.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == 1'b0) begin
              tx_req_d = 1'b1;
              cnt_d    = 3'd1;
            end else begin
              state_d = IDLE;
              oen_d   = 1'b0;
            end
          end else if (scl_fall && cnt_q == 3'd1) begin
            state_d = RD_DATA;
            oen_d   = ~tx_buf_q[7];
            tx_sh_d = {tx_buf_q[6:0], 1'b0};
          end
        end

        default: begin
          state_d = IDLE;
          oen_d   = 1'b0;
        end
      endcase
    end

    if (state_d != state_q || start_det) cnt_d = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      rw_q       <= I2C_WR;
      oen_q      <= 1'b0;
      rx_data    <= 8'h00;
      rx_en      <= 1'b0;
      tx_req     <= 1'b0;
      tx_req_p1  <= 1'b0;
      flag_start <= 1'b0;
      flag_stop  <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      oen_q      <= oen_d;
      rx_data    <= rx_data_d;
      rx_en      <= rx_en_d;
      tx_req     <= tx_req_d;
      tx_req_p1  <= tx_req;
      flag_start <= start_d;
      flag_stop  <= stop_d;
      addr_match <= addr_match_d;
      busy       <= busy_d;
    end
  end

  // tx_req -> p1 -> capture: local logic gets two cycles to present tx_data.
  always_ff @(posedge clk) begin
    rx_sh_q <= rx_sh_d;
    tx_sh_q <= tx_sh_d;
    if (tx_req_p1) tx_buf_q <= tx_data;
  end

  assign bus.sda_oen = oen_q;
  assign bus.sda_out = 1'b0;

endmodule
